// File: rtl/enigma_rotor_cipher.sv
// Ten-byte rotor cipher: shifts letters A..Z by the sum of three odometer rotors
// plus a 5-bit key, one byte per cycle, and presents the block on one pulse.
module enigma_rotor_cipher (
  input  logic        clk,
  input  logic        rst,
  input  logic [79:0] plainIn,
  input  logic        start,
  input  logic        mode,
  input  logic [7:0]  sw,
  input  logic        rotorClr,
  output logic [79:0] cipherOut,
  output logic        sendFlag,
  output logic        busy,
  output logic [14:0] rotorPos
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ENC  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]  state_r;
  logic [3:0]  byteIdx_r;
  logic [79:0] data_r;
  logic        mode_r;
  logic [4:0]  key_r;
  logic [4:0]  rotor0_r;
  logic [4:0]  rotor1_r;
  logic [4:0]  rotor2_r;

  logic [7:0]  curByte_s;
  logic        isLetter_s;
  logic [4:0]  pIdx_s;
  logic [6:0]  offset_s;
  logic [4:0]  offMod_s;
  logic [5:0]  encSum_s;
  logic [4:0]  shifted_s;
  logic [7:0]  outByte_s;
  logic        unusedSw_s;

  assign unusedSw_s = ^sw[7:5];
  assign rotorPos   = {rotor2_r, rotor1_r, rotor0_r};

  // Substitute the byte at the head of the working register using current rotors
  always_comb begin
    curByte_s  = data_r[79:72];
    isLetter_s = (curByte_s >= 8'h41) && (curByte_s <= 8'h5A);
    pIdx_s     = 5'(curByte_s - 8'h41);
    offset_s   = {2'b00, rotor0_r} + {2'b00, rotor1_r} + {2'b00, rotor2_r} + {2'b00, key_r};
    offMod_s   = 5'(offset_s % 7'd26);
    encSum_s   = {1'b0, pIdx_s} + {1'b0, offMod_s};
    shifted_s  = 5'd0;
    outByte_s  = curByte_s;
    if (isLetter_s) begin
      if (mode_r) begin
        if (pIdx_s >= offMod_s) begin
          shifted_s = pIdx_s - offMod_s;
        end else begin
          shifted_s = 5'({1'b0, pIdx_s} + 6'd26 - {1'b0, offMod_s});
        end
      end else begin
        if (encSum_s >= 6'd26) begin
          shifted_s = 5'(encSum_s - 6'd26);
        end else begin
          shifted_s = encSum_s[4:0];
        end
      end
      outByte_s = 8'h41 + {3'b000, shifted_s};
    end else begin
      outByte_s = curByte_s;
    end
  end

  // Control FSM, byte assembly (results shift in behind the plaintext) and rotor stepping
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      byteIdx_r <= 4'd0;
      data_r    <= 80'd0;
      mode_r    <= 1'b0;
      key_r     <= 5'd0;
      rotor0_r  <= 5'd0;
      rotor1_r  <= 5'd0;
      rotor2_r  <= 5'd0;
      cipherOut <= 80'd0;
      sendFlag  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          sendFlag <= 1'b0;
          if (rotorClr) begin
            rotor0_r <= 5'd0;
            rotor1_r <= 5'd0;
            rotor2_r <= 5'd0;
          end
          if (start) begin
            data_r    <= plainIn;
            mode_r    <= mode;
            key_r     <= sw[4:0];
            byteIdx_r <= 4'd0;
            busy      <= 1'b1;
            state_r   <= ENC;
          end
        end
        ENC: begin
          data_r <= {data_r[71:0], outByte_s};
          if (isLetter_s) begin
            if (rotor0_r == 5'd25) begin
              rotor0_r <= 5'd0;
              if (rotor1_r == 5'd25) begin
                rotor1_r <= 5'd0;
                rotor2_r <= (rotor2_r == 5'd25) ? 5'd0 : rotor2_r + 5'd1;
              end else begin
                rotor1_r <= rotor1_r + 5'd1;
              end
            end else begin
              rotor0_r <= rotor0_r + 5'd1;
            end
          end
          if (byteIdx_r == 4'd9) begin
            cipherOut <= {data_r[71:0], outByte_s};
            sendFlag  <= 1'b1;
            state_r   <= DONE;
          end else begin
            byteIdx_r <= byteIdx_r + 4'd1;
          end
        end
        DONE: begin
          sendFlag <= 1'b0;
          busy     <= 1'b0;
          state_r  <= IDLE;
        end
        default: begin
          sendFlag <= 1'b0;
          busy     <= 1'b0;
          state_r  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_enigma_rotor_cipher.sv
// Directed bench for enigma_rotor_cipher with hand-computed expected blocks.
module tb_enigma_rotor_cipher;

  logic        clk;
  logic        rst;
  logic [79:0] plainIn;
  logic        start;
  logic        mode;
  logic [7:0]  sw;
  logic        rotorClr;
  logic [79:0] cipherOut;
  logic        sendFlag;
  logic        busy;
  logic [14:0] rotorPos;

  int passCnt;
  int totalCnt;

  localparam logic [79:0] A10   = 80'h41414141414141414141;
  localparam logic [79:0] HELLO = 80'h48454C4C4F2057524C44;

  enigma_rotor_cipher dut (
    .clk(clk), .rst(rst), .plainIn(plainIn), .start(start), .mode(mode),
    .sw(sw), .rotorClr(rotorClr), .cipherOut(cipherOut), .sendFlag(sendFlag),
    .busy(busy), .rotorPos(rotorPos)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [79:0] got, input logic [79:0] exp);
    totalCnt++;
    if (got === exp) begin
      passCnt++;
    end else begin
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Starts one message, scrambles the inputs afterwards, and watches 14 cycles.
  task automatic runMsg(input logic [79:0] p, input logic m, input logic [7:0] k,
                        input logic clr, input logic busyPoke, input logic donePoke,
                        output logic [79:0] res);
    int lat;
    int flags;
    plainIn = p; mode = m; sw = k; rotorClr = clr; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; rotorClr = 1'b0;
    plainIn = {80{1'b1}}; mode = ~m; sw = ~k;
    lat = 0; flags = 0; res = 80'd0;
    checkVal("busyOn", {79'd0, busy}, 80'd1);
    for (int i = 1; i <= 14; i++) begin
      @(posedge clk); #1;
      start = 1'b0; rotorClr = 1'b0;
      if (sendFlag) begin
        flags++;
        if (lat == 0) begin
          lat = i;
          res = cipherOut;
        end
      end
      if (i == 10) checkVal("busyDone", {79'd0, busy}, 80'd1);
      if (i == 11) checkVal("busyOff", {79'd0, busy}, 80'd0);
      if (busyPoke && i == 3) begin
        start = 1'b1; rotorClr = 1'b1;
      end
      if (donePoke && i == 10) start = 1'b1;
    end
    checkVal("latency", 80'(lat), 80'd10);
    checkVal("pulses", 80'(flags), 80'd1);
  endtask

  initial begin
    logic [79:0] res;
    logic [79:0] enc;
    int flags;
    passCnt = 0; totalCnt = 0;
    rst = 1'b1; plainIn = 80'd0; start = 1'b0; mode = 1'b0; sw = 8'd0; rotorClr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkVal("rstCipher", cipherOut, 80'd0);
    checkVal("rstFlag", {79'd0, sendFlag}, 80'd0);
    checkVal("rstBusy", {79'd0, busy}, 80'd0);
    checkVal("rstRotor", {65'd0, rotorPos}, 80'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    runMsg(A10, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, res);
    checkVal("aaaCipher", res, 80'h4142434445464748494A);
    checkVal("aaaRotor", {65'd0, rotorPos}, 80'd10);

    runMsg(80'h5A5A5A5A5A5A5A5A5A5A, 1'b0, 8'h03, 1'b1, 1'b0, 1'b0, res);
    checkVal("zzzCipher", res, 80'h434445464748494A4B4C);

    runMsg(80'h41204120412041204120, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, res);
    checkVal("spaceCipher", res, 80'h41204220432044204520);
    checkVal("spaceRotor", {65'd0, rotorPos}, 80'd5);

    // Third message: r0 runs 20..25, wraps, then r1=1 adds to the offset.
    runMsg(A10, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, res);
    checkVal("wrap1", res, 80'h4142434445464748494A);
    runMsg(A10, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, res);
    checkVal("wrap2", res, 80'h4B4C4D4E4F5051525354);
    runMsg(A10, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, res);
    checkVal("wrap3", res, 80'h55565758595A42434445);
    checkVal("wrapRotor", {65'd0, rotorPos}, {65'd0, 5'd0, 5'd1, 5'd4});

    runMsg(HELLO, 1'b0, 8'h11, 1'b1, 1'b0, 1'b0, enc);
    checkVal("rtEnc", enc, 80'h595745464A20534F4A43);
    checkVal("rtRotor", {65'd0, rotorPos}, 80'd9);
    runMsg(enc, 1'b1, 8'h11, 1'b1, 1'b0, 1'b0, res);
    checkVal("rtDec", res, HELLO);

    // start and rotorClr raised mid-message must have no effect.
    runMsg(A10, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, res);
    checkVal("pokeCipher", res, 80'h4142434445464748494A);
    checkVal("pokeRotor", {65'd0, rotorPos}, 80'd10);

    runMsg(A10, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, res);
    checkVal("doneStart", res, 80'h4142434445464748494A);
    checkVal("doneRotor", {65'd0, rotorPos}, 80'd10);

    // Abort a message with rst sampled at edge T+5.
    plainIn = A10; mode = 1'b0; sw = 8'h00; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    checkVal("abCipher", cipherOut, 80'd0);
    checkVal("abFlag", {79'd0, sendFlag}, 80'd0);
    checkVal("abBusy", {79'd0, busy}, 80'd0);
    checkVal("abRotor", {65'd0, rotorPos}, 80'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    flags = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      if (sendFlag) flags++;
    end
    checkVal("abNoPulse", 80'(flags), 80'd0);
    checkVal("abHold", cipherOut, 80'd0);

    runMsg(A10, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, res);
    checkVal("postRst", res, 80'h4142434445464748494A);

    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
